// File: rtl/sad_pkg.sv
// Shared constants, match/result field layout and FSM states for the SAD refinement stage.
package sad_pkg;
  localparam int unsigned IMG_W  = 640;
  localparam int unsigned IMG_H  = 480;
  localparam int unsigned HALF   = 2;
  localparam int unsigned RANGE  = 2;
  localparam int unsigned WIN    = 2 * HALF + 1;
  localparam int unsigned NCAND  = 2 * RANGE + 1;
  localparam int unsigned RD_LAT = 2;

  localparam int unsigned CW     = 10;
  localparam int unsigned XYO_W  = 22;
  localparam int unsigned X_LSB  = 12;
  localparam int unsigned Y_LSB  = 2;
  localparam int unsigned O_LSB  = 0;
  localparam int unsigned BW     = 12;
  localparam int unsigned SAD_W  = 13;
  localparam int unsigned OFF_W  = 3;
  localparam int unsigned IDX_W  = 15;
  localparam int unsigned PIX_AW = 19;
  localparam int unsigned DW     = 3;
  localparam int unsigned CNT_W  = 2;

  localparam logic [SAD_W-1:0] SAD_MAX = 13'h1FFF;

  typedef struct packed {
    logic             valid;
    logic [OFF_W-1:0] offset;
    logic [SAD_W-1:0] best_sad;
    logic [XYO_W-1:0] xyo_left;
    logic [XYO_W-1:0] xyo_right;
  } res_t;

  localparam int unsigned RES_W = $bits(res_t);

  // Sideband travelling with each addressed pixel pair through the read pipeline.
  typedef struct packed {
    logic          valid;
    logic          first;
    logic          last;
    logic [DW-1:0] d;
  } tag_t;

  typedef enum logic [2:0] {IDLE, FETCH, CHECK, SCAN, DRAIN, WRITE, DONE} state_e;
endpackage

// File: rtl/sad_accum.sv
// Abs-diff stage, per-candidate SAD accumulator and best-candidate tracker.
module sad_accum
  import sad_pkg::*;
(
  input  logic             clk,
  input  logic             rst_n,
  input  logic             init,
  input  logic             in_valid,
  input  logic             in_first,
  input  logic             in_last,
  input  logic [DW-1:0]    in_d,
  input  logic [7:0]       pix_l,
  input  logic [7:0]       pix_r,
  output logic [SAD_W-1:0] best_sad_c,
  output logic [DW-1:0]    best_d_c
);
  logic [7:0]       ad_q, ad_d;
  logic             valid_q, valid_d, first_q, first_d, last_q, last_d;
  logic [DW-1:0]    d_q, d_d, best_d_q, best_d_d;
  logic [SAD_W-1:0] acc_q, acc_d, best_sad_q, best_sad_d, sum;

  // Best tracker is exposed one cycle early so the writer sees the final candidate.
  always_comb begin
    ad_d       = (pix_l > pix_r) ? pix_l - pix_r : pix_r - pix_l;
    valid_d    = in_valid;
    first_d    = in_first;
    last_d     = in_last;
    d_d        = in_d;
    sum        = (first_q ? '0 : acc_q) + SAD_W'(ad_q);
    acc_d      = valid_q ? sum : acc_q;
    best_sad_d = best_sad_q;
    best_d_d   = best_d_q;
    if (init) begin
      best_sad_d = SAD_MAX;
      best_d_d   = '0;
    end else if (valid_q && last_q && (sum < best_sad_q)) begin
      best_sad_d = sum;
      best_d_d   = d_q;
    end
  end

  assign best_sad_c = best_sad_d;
  assign best_d_c   = best_d_d;

  always_ff @(posedge clk) begin
    if (!rst_n) begin
      ad_q       <= '0;
      valid_q    <= 1'b0;
      first_q    <= 1'b0;
      last_q     <= 1'b0;
      d_q        <= '0;
      acc_q      <= '0;
      best_sad_q <= SAD_MAX;
      best_d_q   <= '0;
    end else begin
      ad_q       <= ad_d;
      valid_q    <= valid_d;
      first_q    <= first_d;
      last_q     <= last_d;
      d_q        <= d_d;
      acc_q      <= acc_d;
      best_sad_q <= best_sad_d;
      best_d_q   <= best_d_d;
    end
  end
endmodule

// File: rtl/sad_refine.sv
// Stereo SAD refinement: per match, searches NCAND horizontal offsets with a WIN x WIN block SAD.
module sad_refine
  import sad_pkg::*;
(
  input  logic                 clk,
  input  logic                 rst_n,
  input  logic                 start,
  input  logic [IDX_W-1:0]     num_matches,
  output logic [IDX_W-1:0]     match_addr,
  input  logic [2*XYO_W-1:0]   match_data,
  output logic [PIX_AW-1:0]    pix_addr_left,
  output logic [PIX_AW-1:0]    pix_addr_right,
  input  logic [7:0]           pix_left,
  input  logic [7:0]           pix_right,
  output logic [IDX_W-1:0]     res_addr,
  output logic [RES_W-1:0]     res_data,
  output logic                 res_wren,
  output logic                 busy,
  output logic                 done
);
  localparam logic signed [BW-1:0] ZERO_S = '0;
  localparam logic signed [BW-1:0] HALF_S = BW'(HALF);
  localparam logic signed [BW-1:0] HR_S   = BW'(HALF + RANGE);
  localparam logic signed [BW-1:0] XMAX_S = BW'(IMG_W - 1);
  localparam logic signed [BW-1:0] YMAX_S = BW'(IMG_H - 1);

  state_e               state_q, state_d;
  logic [IDX_W-1:0]     idx_q, idx_d, num_q, num_d;
  logic [CNT_W-1:0]     cnt_q, cnt_d;
  logic [DW-1:0]        ci_q, ci_d, cj_q, cj_d, cd_q, cd_d;
  logic [2*XYO_W-1:0]   match_q, match_d;
  tag_t                 cur_tag_q, cur_tag_d;
  tag_t [RD_LAT-1:0]    tag_pipe_q, tag_pipe_d;
  logic [IDX_W-1:0]     match_addr_q, match_addr_d, res_addr_q, res_addr_d;
  logic [PIX_AW-1:0]    pix_addr_left_q, pix_addr_left_d, pix_addr_right_q, pix_addr_right_d;
  res_t                 res_data_q, res_data_d;
  logic                 res_wren_q, res_wren_d, busy_q, busy_d, done_q, done_d;

  logic [XYO_W-1:0]     xyo_l, xyo_r;
  logic [CW-1:0]        x_l, y_l, x_r;
  logic signed [BW-1:0] xl_s, yl_s, xr_s;
  logic                 in_bounds;
  logic [PIX_AW-1:0]    row, base;
  logic [SAD_W-1:0]     best_sad;
  logic [DW-1:0]        best_d;

  assign xyo_l = match_q[2*XYO_W-1 -: XYO_W];
  assign xyo_r = match_q[XYO_W-1:0];
  assign x_l   = xyo_l[X_LSB +: CW];
  assign y_l   = xyo_l[Y_LSB +: CW];
  assign x_r   = xyo_r[X_LSB +: CW];
  assign xl_s  = signed'(BW'(x_l));
  assign yl_s  = signed'(BW'(y_l));
  assign xr_s  = signed'(BW'(x_r));

  // Window plus search range must stay fully inside both images.
  assign in_bounds = (yl_s - HALF_S >= ZERO_S) && (yl_s + HALF_S <= YMAX_S) &&
                     (xl_s - HALF_S >= ZERO_S) && (xl_s + HALF_S <= XMAX_S) &&
                     (xr_s - HR_S >= ZERO_S)   && (xr_s + HR_S <= XMAX_S);

  always_ff @(posedge clk) begin
    if (!rst_n) begin
      state_q          <= IDLE;
      idx_q            <= '0;
      num_q            <= '0;
      cnt_q            <= '0;
      ci_q             <= '0;
      cj_q             <= '0;
      cd_q             <= '0;
      match_q          <= '0;
      cur_tag_q        <= '0;
      tag_pipe_q       <= '0;
      match_addr_q     <= '0;
      pix_addr_left_q  <= '0;
      pix_addr_right_q <= '0;
      res_addr_q       <= '0;
      res_data_q       <= '0;
      res_wren_q       <= 1'b0;
      busy_q           <= 1'b0;
      done_q           <= 1'b0;
    end else begin
      state_q          <= state_d;
      idx_q            <= idx_d;
      num_q            <= num_d;
      cnt_q            <= cnt_d;
      ci_q             <= ci_d;
      cj_q             <= cj_d;
      cd_q             <= cd_d;
      match_q          <= match_d;
      cur_tag_q        <= cur_tag_d;
      tag_pipe_q       <= tag_pipe_d;
      match_addr_q     <= match_addr_d;
      pix_addr_left_q  <= pix_addr_left_d;
      pix_addr_right_q <= pix_addr_right_d;
      res_addr_q       <= res_addr_d;
      res_data_q       <= res_data_d;
      res_wren_q       <= res_wren_d;
      busy_q           <= busy_d;
      done_q           <= done_d;
    end
  end

  // Next state, match index, phase counters and scan position.
  always_comb begin
    state_d = state_q;
    idx_d   = idx_q;
    num_d   = num_q;
    cnt_d   = cnt_q;
    ci_d    = ci_q;
    cj_d    = cj_q;
    cd_d    = cd_q;
    match_d = match_q;
    if (start) begin
      num_d   = num_matches;
      idx_d   = '0;
      cnt_d   = '0;
      state_d = (num_matches == '0) ? DONE : FETCH;
    end else begin
      unique case (state_q)
        FETCH: begin
          if (cnt_q == CNT_W'(RD_LAT)) begin
            match_d = match_data;
            cnt_d   = '0;
            state_d = CHECK;
          end else begin
            cnt_d = cnt_q + CNT_W'(1);
          end
        end
        CHECK: begin
          ci_d    = '0;
          cj_d    = '0;
          cd_d    = '0;
          state_d = in_bounds ? SCAN : WRITE;
        end
        SCAN: begin
          if (ci_q == DW'(WIN - 1)) begin
            ci_d = '0;
            if (cj_q == DW'(WIN - 1)) begin
              cj_d = '0;
              if (cd_q == DW'(NCAND - 1)) begin
                cnt_d   = '0;
                state_d = DRAIN;
              end else begin
                cd_d = cd_q + DW'(1);
              end
            end else begin
              cj_d = cj_q + DW'(1);
            end
          end else begin
            ci_d = ci_q + DW'(1);
          end
        end
        DRAIN: begin
          if (cnt_q == CNT_W'(RD_LAT)) state_d = WRITE;
          else cnt_d = cnt_q + CNT_W'(1);
        end
        WRITE: begin
          if (idx_q == num_q - IDX_W'(1)) begin
            state_d = DONE;
          end else begin
            idx_d   = idx_q + IDX_W'(1);
            cnt_d   = '0;
            state_d = FETCH;
          end
        end
        DONE:    state_d = IDLE;
        default: state_d = IDLE;
      endcase
    end
  end

  // Registered outputs, pixel addressing and the result word.
  always_comb begin
    match_addr_d     = match_addr_q;
    pix_addr_left_d  = pix_addr_left_q;
    pix_addr_right_d = pix_addr_right_q;
    res_addr_d       = res_addr_q;
    res_data_d       = res_data_q;
    res_wren_d       = 1'b0;
    busy_d           = state_d inside {FETCH, CHECK, SCAN, DRAIN, WRITE};
    done_d           = (state_d == DONE);
    cur_tag_d        = '0;
    tag_pipe_d       = {tag_pipe_q[RD_LAT-2:0], cur_tag_q};
    row              = PIX_AW'(y_l) + PIX_AW'(cj_d) - PIX_AW'(HALF);
    base             = PIX_AW'(row * PIX_AW'(IMG_W));

    if (state_d == FETCH && cnt_d == '0) match_addr_d = idx_d;

    if (state_d == SCAN) begin
      pix_addr_left_d  = base + PIX_AW'(x_l) + PIX_AW'(ci_d) - PIX_AW'(HALF);
      pix_addr_right_d = base + PIX_AW'(x_r) + PIX_AW'(cd_d) + PIX_AW'(ci_d) - PIX_AW'(HALF + RANGE);
      cur_tag_d.valid  = 1'b1;
      cur_tag_d.first  = (ci_d == '0) && (cj_d == '0);
      cur_tag_d.last   = (ci_d == DW'(WIN - 1)) && (cj_d == DW'(WIN - 1));
      cur_tag_d.d      = cd_d;
    end

    if (state_d == WRITE) begin
      res_wren_d          = 1'b1;
      res_addr_d          = idx_q;
      res_data_d.xyo_left = xyo_l;
      if (state_q == CHECK) begin
        res_data_d.valid     = 1'b0;
        res_data_d.offset    = '0;
        res_data_d.best_sad  = SAD_MAX;
        res_data_d.xyo_right = xyo_r;
      end else begin
        res_data_d.valid     = (best_d != '0) && (best_d != DW'(NCAND - 1));
        res_data_d.offset    = OFF_W'(best_d) - OFF_W'(RANGE);
        res_data_d.best_sad  = best_sad;
        res_data_d.xyo_right = {x_r + CW'(best_d) - CW'(RANGE), xyo_r[X_LSB-1:0]};
      end
    end
  end

  sad_accum u_accum (
    .clk        (clk),
    .rst_n      (rst_n),
    .init       (state_q == CHECK),
    .in_valid   (tag_pipe_q[RD_LAT-1].valid),
    .in_first   (tag_pipe_q[RD_LAT-1].first),
    .in_last    (tag_pipe_q[RD_LAT-1].last),
    .in_d       (tag_pipe_q[RD_LAT-1].d),
    .pix_l      (pix_left),
    .pix_r      (pix_right),
    .best_sad_c (best_sad),
    .best_d_c   (best_d)
  );

  assign match_addr     = match_addr_q;
  assign pix_addr_left  = pix_addr_left_q;
  assign pix_addr_right = pix_addr_right_q;
  assign res_addr       = res_addr_q;
  assign res_data       = res_data_q;
  assign res_wren       = res_wren_q;
  assign busy           = busy_q;
  assign done           = done_q;
endmodule

// File: tb/tb_sad_refine.sv
// Randomised bench for sad_refine against a direct block-SAD reference model.
module tb_sad_refine;
  localparam int H = 2, R = 2, IW = 640, IH = 480;

  logic        clk = 1'b0, rst_n = 1'b0, start = 1'b0;
  logic [14:0] num_matches = '0, match_addr, res_addr;
  logic [43:0] match_data = '0;
  logic [18:0] pix_addr_left, pix_addr_right;
  logic [7:0]  pix_left = '0, pix_right = '0;
  logic [60:0] res_data;
  logic        res_wren, busy, done;

  sad_refine dut (
    .clk(clk), .rst_n(rst_n), .start(start), .num_matches(num_matches),
    .match_addr(match_addr), .match_data(match_data),
    .pix_addr_left(pix_addr_left), .pix_addr_right(pix_addr_right),
    .pix_left(pix_left), .pix_right(pix_right),
    .res_addr(res_addr), .res_data(res_data), .res_wren(res_wren),
    .busy(busy), .done(done)
  );

  always #5 clk = ~clk;

  // Image content: 0 flat grey, 1 right = left shifted by shift_amt, 2 independent noise.
  int mode = 2, shift_amt = 0, seed = 1;
  logic [43:0] mram [16];

  function automatic logic [7:0] hash8(input int x, input int y, input int s);
    logic [31:0] h;
    h = 32'(x) * 32'd73856093 ^ 32'(y) * 32'd19349663 ^ 32'(s);
    h = h ^ (h >> 13);
    h = h * 32'h5bd1e995;
    h = h ^ (h >> 15);
    return h[7:0];
  endfunction

  function automatic logic [7:0] lpx(input int x, input int y);
    return (mode == 0) ? 8'd128 : hash8(x, y, seed);
  endfunction

  function automatic logic [7:0] rpx(input int x, input int y);
    if (mode == 0) return 8'd128;
    if (mode == 1) return lpx(x + shift_amt, y);
    return hash8(x, y, seed + 1);
  endfunction

  function automatic logic [21:0] xyo(input int x, input int y, input int o);
    return {10'(x), 10'(y), 2'(o)};
  endfunction

  function automatic logic [60:0] ref_res(input logic [43:0] m);
    int xl = int'(m[43:34]);
    int yl = int'(m[33:24]);
    int xr = int'(m[21:12]);
    int best = 8191, bd = 0, s, a, b;
    if (yl - H < 0 || yl + H > IH - 1 || xl - H < 0 || xl + H > IW - 1 ||
        xr - H - R < 0 || xr + H + R > IW - 1)
      return {1'b0, 3'b000, 13'h1FFF, m};
    for (int d = -R; d <= R; d++) begin
      s = 0;
      for (int j = -H; j <= H; j++)
        for (int i = -H; i <= H; i++) begin
          a = int'(lpx(xl + i, yl + j));
          b = int'(rpx(xr + d + i, yl + j));
          s += (a > b) ? a - b : b - a;
        end
      if (s < best) begin best = s; bd = d; end
    end
    return {(bd != -R && bd != R), 3'(bd), 13'(best), m[43:22], 10'(xr + bd), m[11:0]};
  endfunction

  function automatic logic [43:0] rand_match(input bit inb);
    int xl, yl, xr;
    if (inb) begin
      xl = $urandom_range(637, 2); yl = $urandom_range(477, 2); xr = $urandom_range(635, 4);
    end else begin
      xl = $urandom_range(639, 0); yl = $urandom_range(479, 0); xr = $urandom_range(639, 0);
    end
    return {xyo(xl, yl, $urandom_range(3, 0)), xyo(xr, $urandom_range(479, 0), $urandom_range(3, 0))};
  endfunction

  // RAM models with two-cycle read latency.
  logic [43:0] m1 = '0;
  logic [7:0]  l1 = '0, r1 = '0;
  always @(posedge clk) begin
    m1 <= mram[match_addr[3:0]];
    match_data <= m1;
    l1 <= lpx(int'(pix_addr_left) % IW, int'(pix_addr_left) / IW);
    pix_left <= l1;
    r1 <= rpx(int'(pix_addr_right) % IW, int'(pix_addr_right) / IW);
    pix_right <= r1;
  end

  // Write/event log.
  int          cyc = 0, done_cnt = 0, busy_rise = 0, busy_cnt = 0, pix_chg = 0;
  logic        busy_prev = 1'b0;
  logic [18:0] pl_prev = '0;
  int          wr_addr_q[$], wr_cyc_q[$];
  logic [60:0] wr_data_q[$];

  always @(posedge clk) cyc++;
  always @(negedge clk) begin
    if (res_wren === 1'b1) begin
      wr_addr_q.push_back(int'(res_addr));
      wr_data_q.push_back(res_data);
      wr_cyc_q.push_back(cyc);
    end
    if (done === 1'b1) done_cnt++;
    if (busy === 1'b1) busy_cnt++;
    if (busy === 1'b1 && busy_prev !== 1'b1) busy_rise = cyc;
    if (pix_addr_left !== pl_prev) pix_chg++;
    busy_prev = busy;
    pl_prev = pix_addr_left;
  end

  int n_tests = 0, n_fail = 0;

  task automatic check(input string tag, input logic [63:0] got, input logic [63:0] exp);
    n_tests++;
    if (got !== exp) begin
      n_fail++;
      $display("FAIL %s: got 0x%0h expected 0x%0h", tag, got, exp);
    end
  endtask

  task automatic clear_log();
    wr_addr_q.delete(); wr_data_q.delete(); wr_cyc_q.delete();
  endtask

  task automatic pulse_start(input int num);
    @(negedge clk); start = 1'b1; num_matches = 15'(num);
    @(negedge clk); start = 1'b0; #1;
  endtask

  task automatic wait_done(input int d0, input int limit, output bit ok);
    int t = 0;
    while (done_cnt == d0 && t < limit) begin @(negedge clk); #1; t++; end
    ok = (done_cnt != d0);
  endtask

  task automatic run_job(input int num, input int limit);
    int d0 = done_cnt;
    bit ok;
    pulse_start(num);
    wait_done(d0, limit, ok);
    check("job_done", 64'(ok), 64'd1);
  endtask

  task automatic check_writes(input int first, input int num);
    for (int k = 0; k < num; k++) begin
      if (first + k < wr_addr_q.size()) begin
        check($sformatf("wr_addr_%0d", k), 64'(wr_addr_q[first + k]), 64'(k));
        check($sformatf("wr_data_%0d", k), 64'(wr_data_q[first + k]), 64'(ref_res(mram[k])));
      end else begin
        check($sformatf("wr_missing_%0d", k), 64'(wr_addr_q.size()), 64'(first + num));
      end
    end
  endtask

  initial begin
    #1_000_000;
    $display("FAIL watchdog: simulation did not finish");
    $fatal(1, "watchdog");
  end

  initial begin
    int d0, b0, p0, t;
    bit ok;

    repeat (3) @(negedge clk);
    #1;
    check("rst_busy", 64'(busy), 64'd0);
    check("rst_done", 64'(done), 64'd0);
    check("rst_wren", 64'(res_wren), 64'd0);
    check("rst_maddr", 64'(match_addr), 64'd0);
    check("rst_paddr", 64'({pix_addr_left, pix_addr_right}), 64'd0);
    check("rst_res", 64'({res_addr, res_data}), 64'd0);
    rst_n = 1'b1;

    // Empty job: done the cycle after start, never busy, no writes.
    clear_log();
    b0 = busy_cnt; d0 = done_cnt;
    pulse_start(0);
    check("zero_done", 64'(done), 64'd1);
    check("zero_busy", 64'(busy), 64'd0);
    @(negedge clk); #1;
    check("zero_done_pulse", 64'(done), 64'd0);
    check("zero_done_cnt", 64'(done_cnt - d0), 64'd1);
    check("zero_nbusy", 64'(busy_cnt - b0), 64'd0);
    check("zero_nwr", 64'(wr_addr_q.size()), 64'd0);

    // Right image shifted so the true offset is +1.
    mode = 1; shift_amt = 9; seed = 7;
    mram[0] = {xyo(100, 50, 1), xyo(90, 50, 2)};
    clear_log();
    run_job(1, 400);
    check("shift_nwr", 64'(wr_addr_q.size()), 64'd1);
    check_writes(0, 1);
    if (wr_data_q.size() > 0) begin
      check("shift_valid", 64'(wr_data_q[0][60]), 64'd1);
      check("shift_off", 64'(wr_data_q[0][59:57]), 64'd1);
      check("shift_sad", 64'(wr_data_q[0][56:44]), 64'd0);
      check("shift_xr", 64'(wr_data_q[0][21:12]), 64'd91);
      check("shift_lat", 64'(wr_cyc_q[0] - busy_rise), 64'd132);
    end

    // Window off the left edge: short path, no pixel traffic.
    mode = 2; seed = 11;
    mram[0] = {xyo(1, 50, 0), xyo(90, 50, 3)};
    clear_log();
    p0 = pix_chg;
    run_job(1, 100);
    check("oob_nwr", 64'(wr_addr_q.size()), 64'd1);
    check_writes(0, 1);
    if (wr_data_q.size() > 0) begin
      check("oob_word", 64'(wr_data_q[0]), 64'({1'b0, 3'b000, 13'h1FFF, mram[0]}));
      check("oob_lat", 64'(wr_cyc_q[0] - busy_rise), 64'd4);
    end
    check("oob_no_pix", 64'(pix_chg - p0), 64'd0);

    // Flat images: all candidates tie, earliest offset wins.
    mode = 0;
    mram[0] = {xyo(200, 100, 3), xyo(180, 100, 1)};
    clear_log();
    run_job(1, 400);
    check_writes(0, 1);
    if (wr_data_q.size() > 0) begin
      check("flat_valid", 64'(wr_data_q[0][60]), 64'd0);
      check("flat_off", 64'(wr_data_q[0][59:57]), 64'b110);
      check("flat_sad", 64'(wr_data_q[0][56:44]), 64'd0);
      check("flat_xr", 64'(wr_data_q[0][21:12]), 64'd178);
    end

    // Random batch, mostly in bounds.
    mode = 2; seed = $urandom;
    for (int k = 0; k < 8; k++) mram[k] = rand_match(($urandom % 4) != 0);
    clear_log();
    run_job(8, 8 * 140 + 50);
    check("rand_nwr", 64'(wr_addr_q.size()), 64'd8);
    check_writes(0, 8);

    // Re-start during the second match's scan.
    mode = 1; shift_amt = $urandom_range(12, 0); seed = $urandom;
    for (int k = 0; k < 3; k++) mram[k] = rand_match(1'b1);
    clear_log();
    d0 = done_cnt;
    pulse_start(3);
    t = 0;
    while (wr_addr_q.size() < 1 && t < 300) begin @(negedge clk); #1; t++; end
    check("abort_first_wr", 64'(wr_addr_q.size()), 64'd1);
    repeat (40) @(negedge clk);
    pulse_start(3);
    wait_done(d0, 600, ok);
    check("abort_done", 64'(ok), 64'd1);
    check("abort_done_cnt", 64'(done_cnt - d0), 64'd1);
    check("abort_nwr", 64'(wr_addr_q.size()), 64'd4);
    check_writes(1, 3);

    // Reset in the middle of a scan.
    mram[0] = rand_match(1'b1);
    clear_log();
    pulse_start(1);
    repeat (40) @(negedge clk);
    rst_n = 1'b0;
    @(negedge clk); #1;
    check("mrst_busy", 64'(busy), 64'd0);
    check("mrst_wren", 64'(res_wren), 64'd0);
    check("mrst_addr", 64'({match_addr, pix_addr_left, pix_addr_right}), 64'd0);
    check("mrst_res", 64'({res_addr, res_data}), 64'd0);
    rst_n = 1'b1;
    repeat (200) @(negedge clk);
    #1;
    check("mrst_nwr", 64'(wr_addr_q.size()), 64'd0);
    check("mrst_idle", 64'({busy, done}), 64'd0);

    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end
endmodule
